pixel_index_fetch: RTL and testbench

Pipelined upstream stage of the palette lookup. Per pixel, it turns the VGA scan position into sync-ROM addresses for the start screen, the map background and the player sprite, then resolves sprite-over-map transparency. It emits the palette `select` code and the matching index for the palette lookup, with hs/vs/blank delayed to stay pixel-aligned. A frame-synchronous mode FSM switches between start screen and map only at frame boundaries.

---
 rtl/pixel_index_fetch.sv | 161 ++++++++++++++++
 tb/tb_pixel_index_fetch.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_index_fetch.sv
// Three-stage pixel pipeline: scan position -> ROM addresses -> palette select/index,
// with a frame-synchronous start/map mode and sprite-over-map transparency.
module pixel_index_fetch #(
  parameter int unsigned SPRITE_W = 16,
  parameter int unsigned SPRITE_H = 16,
  parameter int unsigned BG_SHIFT = 1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        start_mode,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic [1:0]  sprite_frame,
  output logic [16:0] map_addr,
  output logic [16:0] start_addr,
  output logic [9:0]  sprite_addr,
  input  logic [7:0]  map_data,
  input  logic [4:0]  start_data,
  input  logic [3:0]  sprite_data,
  output logic [1:0]  select,
  output logic [3:0]  palette_color,
  output logic [7:0]  map_palette_color,
  output logic [5:0]  start_palette_color,
  output logic        blank_out,
  output logic        hs_out,
  output logic        vs_out
);
  localparam int unsigned BG_W    = 640 >> BG_SHIFT;
  localparam int unsigned SPR_PIX = SPRITE_W * SPRITE_H;

  typedef enum logic {ST_START = 1'b0, ST_MAP = 1'b1} mode_t;

  mode_t       state, state_nxt;
  logic        vs_q;
  logic        vs_fall_c;
  logic [9:0]  sx_sh, sy_sh;
  logic [1:0]  frame_sh;

  assign vs_fall_c = vs_q & ~vs_in;

  // Frame-boundary edge detect and sprite shadow registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_q     <= 1'b1;
      sx_sh    <= '0;
      sy_sh    <= '0;
      frame_sh <= '0;
    end else begin
      vs_q <= vs_in;
      if (vs_fall_c) begin
        sx_sh    <= sprite_x;
        sy_sh    <= sprite_y;
        frame_sh <= sprite_frame;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= ST_START;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (vs_fall_c) state_nxt = start_mode ? ST_START : ST_MAP;
  end

  // Stage 0 address arithmetic
  logic [9:0]  bx_c, by_c;
  logic [16:0] bg_c;
  logic [10:0] dx_c, dy_c;
  logic        hit_c;
  logic [9:0]  spr_c;

  always_comb begin
    bx_c  = DrawX >> BG_SHIFT;
    by_c  = DrawY >> BG_SHIFT;
    bg_c  = 17'(by_c) * 17'(BG_W) + 17'(bx_c);
    dx_c  = 11'(DrawX) - 11'(sx_sh);
    dy_c  = 11'(DrawY) - 11'(sy_sh);
    // Unsigned compare rejects negative offsets, which appear as large values
    hit_c = (dx_c < 11'(SPRITE_W)) && (dy_c < 11'(SPRITE_H));
    spr_c = 10'(frame_sh) * 10'(SPR_PIX) + 10'(dy_c) * 10'(SPRITE_W) + 10'(dx_c);
  end

  logic  hit1, hit2, blank1, blank2, hs1, hs2, vs1, vs2;
  mode_t mode1, mode2;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      map_addr    <= '0;
      start_addr  <= '0;
      sprite_addr <= '0;
      hit1   <= 1'b0;  hit2   <= 1'b0;
      mode1  <= ST_START; mode2 <= ST_START;
      blank1 <= 1'b1;  blank2 <= 1'b1;
      hs1    <= 1'b1;  hs2    <= 1'b1;
      vs1    <= 1'b1;  vs2    <= 1'b1;
    end else begin
      map_addr    <= bg_c;
      start_addr  <= bg_c;
      sprite_addr <= hit_c ? spr_c : 10'd0;
      hit1   <= hit_c;    hit2   <= hit1;
      mode1  <= state;    mode2  <= mode1;
      blank1 <= blank_in; blank2 <= blank1;
      hs1    <= hs_in;    hs2    <= hs1;
      vs1    <= vs_in;    vs2    <= vs1;
    end
  end

  // Stage 2 priority resolve: blank, start screen, opaque sprite, map
  logic [1:0] sel_c;
  logic [3:0] pal_c;
  logic [7:0] map_c;
  logic [5:0] st_c;

  always_comb begin
    sel_c = 2'd2;
    pal_c = '0;
    map_c = '0;
    st_c  = '0;
    if (!blank2) begin
      if (mode2 == ST_START) begin
        sel_c = 2'd3;
        st_c  = {1'b0, start_data};
      end else if (hit2 && (sprite_data != 4'd0)) begin
        sel_c = 2'd0;
        pal_c = sprite_data;
      end else begin
        sel_c = 2'd1;
        map_c = map_data & 8'h7f;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      select              <= 2'd2;
      palette_color       <= '0;
      map_palette_color   <= '0;
      start_palette_color <= '0;
      blank_out           <= 1'b1;
      hs_out              <= 1'b1;
      vs_out              <= 1'b1;
    end else begin
      select              <= sel_c;
      palette_color       <= pal_c;
      map_palette_color   <= map_c;
      start_palette_color <= st_c;
      blank_out           <= blank2;
      hs_out              <= hs2;
      vs_out              <= vs2;
    end
  end

endmodule

// File: tb/tb_pixel_index_fetch.sv
// Bench for pixel_index_fetch: synchronous ROM models plus a frame-level reference
// model that predicts addresses and palette outputs from scan position and shadows.
module tb_pixel_index_fetch;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic        blank_in = 1'b1, hs_in = 1'b1, vs_in = 1'b1;
  logic        start_mode = 1'b0;
  logic [9:0]  sprite_x = '0, sprite_y = '0;
  logic [1:0]  sprite_frame = '0;
  logic [16:0] map_addr, start_addr;
  logic [9:0]  sprite_addr;
  logic [7:0]  map_data = '0;
  logic [4:0]  start_data = '0;
  logic [3:0]  sprite_data = '0;
  logic [1:0]  select;
  logic [3:0]  palette_color;
  logic [7:0]  map_palette_color;
  logic [5:0]  start_palette_color;
  logic        blank_out, hs_out, vs_out;

  always #5 Clk = ~Clk;

  pixel_index_fetch dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank_in(blank_in), .hs_in(hs_in), .vs_in(vs_in), .start_mode(start_mode),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_frame(sprite_frame),
    .map_addr(map_addr), .start_addr(start_addr), .sprite_addr(sprite_addr),
    .map_data(map_data), .start_data(start_data), .sprite_data(sprite_data),
    .select(select), .palette_color(palette_color),
    .map_palette_color(map_palette_color), .start_palette_color(start_palette_color),
    .blank_out(blank_out), .hs_out(hs_out), .vs_out(vs_out)
  );

  // ROM contents; two entries pinned to the documented example values
  logic force_zero = 1'b0;
  function automatic logic [7:0] map_rom(input logic [16:0] a);
    return 8'(32'(a) * 37 + (32'(a) >> 6));
  endfunction
  function automatic logic [4:0] start_rom(input logic [16:0] a);
    if (a == 17'd8050) return 5'd17;
    return 5'(32'(a) * 11 + 3);
  endfunction
  function automatic logic [3:0] sprite_rom(input logic [9:0] a, input logic z);
    if (z) return 4'd0;
    if (a == 10'd565) return 4'd11;
    return 4'((32'(a) * 5) >> 1);
  endfunction

  always @(posedge Clk) begin
    map_data    <= map_rom(map_addr);
    start_data  <= start_rom(start_addr);
    sprite_data <= sprite_rom(sprite_addr, force_zero);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: mode and sprite position as seen by the current frame
  bit          m_start;
  bit          m_vs_prev;
  int          m_sx, m_sy, m_sf;
  logic [22:0] expq[$];

  function automatic logic [22:0] out_vec();
    return {select, palette_color, map_palette_color, start_palette_color,
            blank_out, hs_out, vs_out};
  endfunction

  // One pixel: predict, clock it in, update frame state, check addresses and 2-deep output
  task automatic step(input int x, input int y, input bit bl, input bit hs, input bit vs);
    logic [16:0] a;
    logic [9:0]  sa;
    logic [3:0]  sp, pal;
    logic [7:0]  mp;
    logic [5:0]  st;
    logic [1:0]  sel;
    int          dx, dy;
    bit          hit;
    DrawX = 10'(x); DrawY = 10'(y);
    blank_in = bl; hs_in = hs; vs_in = vs;
    a   = 17'((y / 2) * 320 + (x / 2));
    dx  = x - m_sx;
    dy  = y - m_sy;
    hit = (dx >= 0) && (dx < 16) && (dy >= 0) && (dy < 16);
    sa  = hit ? 10'(m_sf * 256 + dy * 16 + dx) : 10'd0;
    sp  = sprite_rom(sa, force_zero);
    sel = 2'd2; pal = '0; mp = '0; st = '0;
    if (!bl) begin
      if (m_start) begin
        sel = 2'd3; st = {1'b0, start_rom(a)};
      end else if (hit && sp != 4'd0) begin
        sel = 2'd0; pal = sp;
      end else begin
        sel = 2'd1; mp = map_rom(a) & 8'h7f;
      end
    end
    expq.push_back({sel, pal, mp, st, bl, hs, vs});
    @(posedge Clk);
    if (m_vs_prev && !vs) begin
      m_start = start_mode;
      m_sx = int'(sprite_x); m_sy = int'(sprite_y); m_sf = int'(sprite_frame);
    end
    m_vs_prev = vs;
    @(negedge Clk);
    check("addr", {map_addr, start_addr, sprite_addr}, {a, a, sa});
    if (expq.size() == 3) check("pixel", out_vec(), expq.pop_front());
  endtask

  task automatic do_reset();
    #2 Reset_n = 1'b0;
    #1;
    check("rst_out", out_vec(), {2'd2, 4'd0, 8'd0, 6'd0, 3'b111});
    check("rst_addr", {map_addr, start_addr, sprite_addr}, 64'd0);
    expq.delete();
    m_start = 1'b1; m_vs_prev = 1'b1; m_sx = 0; m_sy = 0; m_sf = 0;
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic rand_pixels(input int n, input bit allow_vs);
    int x, y;
    bit vs;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        x = int'($urandom_range(0, 1023)); y = int'($urandom_range(0, 1023));
      end else begin
        x = (m_sx + int'($urandom_range(0, 24)) - 4) & 1023;
        y = (m_sy + int'($urandom_range(0, 20)) - 2) & 1023;
      end
      vs = !(allow_vs && $urandom_range(0, 29) == 0);
      step(x, y, $urandom_range(0, 9) == 0, $urandom_range(0, 7) != 0, vs);
    end
  endtask

  initial begin
    start_mode = 1'b0;
    sprite_x = 10'd200; sprite_y = 10'd120; sprite_frame = 2'd2;
    @(negedge Clk);
    do_reset();

    // Held in START until the first frame boundary, even with start_mode low
    rand_pixels(4, 1'b0);
    step(100, 50, 0, 1, 1);
    check("start_addr", start_addr, 64'd8050);
    step(0, 0, 1, 1, 1);
    step(0, 0, 1, 1, 1);
    check("start_sel", {select, start_palette_color}, {2'd3, 6'd17});

    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 1);
    step(205, 123, 0, 1, 1);
    check("sprite_addr", sprite_addr, 64'd565);
    step(0, 0, 1, 1, 1);
    step(0, 0, 1, 1, 1);
    check("sprite_sel", {select, palette_color}, {2'd0, 4'd11});

    force_zero = 1'b1;
    step(205, 123, 0, 1, 1);
    step(0, 0, 1, 1, 1);
    step(0, 0, 1, 1, 1);
    check("transparent_sel", select, 64'd1);
    force_zero = 1'b0;

    step(199, 121, 0, 1, 1);
    step(216, 121, 0, 1, 1);
    step(215, 121, 0, 1, 1);
    step(200, 135, 0, 1, 1);

    // Sprite at column 0: far right of the line must not wrap into it
    sprite_x = 10'd0; sprite_y = 10'd120;
    step(0, 0, 1, 1, 0);
    step(1023, 125, 0, 1, 1);
    step(5, 125, 0, 1, 1);
    // Mid-frame move is ignored until the next frame boundary
    sprite_x = 10'd300;
    step(305, 125, 0, 1, 1);
    step(3, 125, 0, 1, 1);

    step(10, 10, 0, 0, 1);
    check("hs_k", hs_out, 64'd1);
    step(10, 10, 0, 1, 1);
    check("hs_k1", hs_out, 64'd1);
    step(10, 10, 0, 1, 1);
    check("hs_k2", hs_out, 64'd0);
    step(10, 10, 0, 1, 1);
    check("hs_k3", hs_out, 64'd1);

    for (int blk = 0; blk < 30; blk++) begin
      if ($urandom_range(0, 3) == 0) start_mode = 1'($urandom_range(0, 1));
      else start_mode = 1'b0;
      sprite_x = 10'($urandom_range(0, 1023));
      sprite_y = 10'($urandom_range(0, 1023));
      sprite_frame = 2'($urandom_range(0, 3));
      rand_pixels(50, 1'b1);
    end

    // Asynchronous reset in the middle of a line
    start_mode = 1'b0;
    sprite_x = 10'd40; sprite_y = 10'd40; sprite_frame = 2'd1;
    step(41, 41, 0, 1, 1);
    do_reset();
    rand_pixels(8, 1'b0);
    step(0, 0, 1, 1, 0);
    rand_pixels(40, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
